// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the unified memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    typedef enum logic {INSTR, DATA} port_id_t;

    localparam int CNT_W = 4;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin picker (bit 0 = instruction, bit 1 = data)
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_valid,
    output logic       gnt_id
);

    // under contention the port that did not win last time is picked
    always_comb begin
        gnt_valid = |req;
        gnt_id    = (&req) ? (last == INSTR) : req[1];
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port synchronous memory between fetch and data ports
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              i_stall,
    output logic              d_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t           state;
    state_t           state_n;
    port_id_t         last_gnt;
    port_id_t         gnt_q;
    logic             wr_q;
    logic [CNT_W-1:0] cnt;
    logic             arb_valid;
    logic             arb_id;
    logic             grant;
    logic             done;

    rr_arb2 u_arb (
        .req       ({d_req, i_req}),
        .last      (last_gnt),
        .gnt_valid (arb_valid),
        .gnt_id    (arb_id)
    );

    assign i_stall = i_req & ~i_ack;
    assign d_stall = d_req & ~d_ack;

    // state register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            state <= IDLE;
        else
            state <= state_n;
    end

    // next state; grant only from IDLE, done when the latency count has run out
    always_comb begin
        state_n = state;
        grant   = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: begin
                grant   = arb_valid;
                state_n = arb_valid ? ISSUE : IDLE;
            end
            ISSUE: state_n = WAIT;
            WAIT: begin
                done    = (cnt == '0);
                state_n = done ? RESP : WAIT;
            end
            RESP: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // registered memory strobes, latched request, latency counter, acks and read data
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            last_gnt  <= INSTR;
            gnt_q     <= INSTR;
            wr_q      <= 1'b0;
            cnt       <= '0;
        end else begin
            mem_en <= grant;
            mem_we <= grant & (arb_id == DATA) & d_we;
            if (grant) begin
                mem_addr  <= (arb_id == DATA) ? d_addr : i_addr;
                mem_wdata <= (arb_id == DATA) ? d_wdata : '0;
                gnt_q     <= port_id_t'(arb_id);
                wr_q      <= (arb_id == DATA) & d_we;
            end
            cnt   <= (state == ISSUE) ? CNT_W'(LATENCY - 1)
                   : (state == WAIT && cnt != '0) ? cnt - 1'b1 : cnt;
            i_ack <= done & (gnt_q == INSTR);
            d_ack <= done & (gnt_q == DATA);
            if (done & (gnt_q == INSTR))
                i_rdata <= mem_rdata;
            if (done & (gnt_q == DATA) & ~wr_q)
                d_rdata <= mem_rdata;
            if (done)
                last_gnt <= gnt_q;
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed vectors and corner sequences for the memory arbiter
module tb_unified_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        i_ack, d_ack, i_stall, d_stall, mem_en, mem_we;

    logic        i_req_4, d_req_4, d_we_4;
    logic [31:0] i_addr_4, d_addr_4, d_wdata_4;
    logic [31:0] i_rdata_4, d_rdata_4, mem_addr_4, mem_wdata_4, mem_rdata_4;
    logic        i_ack_4, d_ack_4, i_stall_4, d_stall_4, mem_en_4, mem_we_4;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(1)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .i_stall(i_stall), .d_stall(d_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(4)) dut4 (
        .CLK(CLK), .RESET_N(RESET_N),
        .i_req(i_req_4), .i_addr(i_addr_4), .i_rdata(i_rdata_4), .i_ack(i_ack_4),
        .d_req(d_req_4), .d_we(d_we_4), .d_addr(d_addr_4), .d_wdata(d_wdata_4),
        .d_rdata(d_rdata_4), .d_ack(d_ack_4), .i_stall(i_stall_4), .d_stall(d_stall_4),
        .mem_en(mem_en_4), .mem_we(mem_we_4), .mem_addr(mem_addr_4),
        .mem_wdata(mem_wdata_4), .mem_rdata(mem_rdata_4)
    );

    // memory models: data only valid LATENCY cycles after an enabled edge
    logic [31:0] mem  [0:255];
    logic [31:0] mem4 [0:255];
    logic [31:0] pipe1;
    logic [31:0] pipe4 [4];

    always @(posedge CLK) begin
        if (!RESET_N) begin
            mem[4] <= 32'h0050_0093;
            mem[5] <= 32'h00A0_0113;
        end else if (mem_en && mem_we)
            mem[mem_addr[9:2]] <= mem_wdata;
        pipe1 <= mem_en ? mem[mem_addr[9:2]] : 32'hBAD0_0001;
    end
    assign mem_rdata = pipe1;

    always @(posedge CLK) begin
        if (!RESET_N)
            mem4[4] <= 32'hCAFE_F00D;
        else if (mem_en_4 && mem_we_4)
            mem4[mem_addr_4[9:2]] <= mem_wdata_4;
        pipe4[0] <= mem_en_4 ? mem4[mem_addr_4[9:2]] : 32'hBAD0_0004;
        for (int i = 1; i < 4; i++)
            pipe4[i] <= pipe4[i-1];
    end
    assign mem_rdata_4 = pipe4[3];

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_i;
        logic [31:0] exp_d;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_access(input vec_t v, input int n);
        int cyc;
        @(posedge CLK); #1;
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            i_req = 1'b1; i_addr = v.addr;
        end
        @(negedge CLK);
        chk($sformatf("v%0d stall c0", n), v.is_d ? d_stall : i_stall, 1);
        chk($sformatf("v%0d mem_en c0", n), mem_en, 0);
        @(negedge CLK);
        chk($sformatf("v%0d mem_en c1", n), mem_en, 1);
        chk($sformatf("v%0d mem_addr", n), mem_addr, v.addr);
        chk($sformatf("v%0d mem_we", n), mem_we, v.we);
        if (v.we)
            chk($sformatf("v%0d mem_wdata", n), mem_wdata, v.wdata);
        cyc = 1;
        while (!(i_ack || d_ack) && cyc < 20) begin
            @(negedge CLK);
            cyc++;
        end
        chk($sformatf("v%0d ack cycle", n), cyc, 3);
        chk($sformatf("v%0d i_ack", n), i_ack, !v.is_d);
        chk($sformatf("v%0d d_ack", n), d_ack, v.is_d);
        chk($sformatf("v%0d i_rdata", n), i_rdata, v.exp_i);
        chk($sformatf("v%0d d_rdata", n), d_rdata, v.exp_d);
        chk($sformatf("v%0d stall at ack", n), v.is_d ? d_stall : i_stall, 0);
        @(posedge CLK); #1;
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        @(negedge CLK);
        chk($sformatf("v%0d ack pulse width", n), i_ack | d_ack, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int cyc;
        int k;
        vecs[0] = '{1'b0, 1'b0, 32'h10,  32'h0,         32'h0050_0093, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 32'h0050_0093, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h100, 32'h0,         32'h0050_0093, 32'hDEAD_BEEF};
        vecs[3] = '{1'b0, 1'b0, 32'h14,  32'h0,         32'h00A0_0113, 32'hDEAD_BEEF};
        vecs[4] = '{1'b1, 1'b1, 32'h104, 32'h1234_5678, 32'h00A0_0113, 32'hDEAD_BEEF};
        vecs[5] = '{1'b1, 1'b0, 32'h10,  32'h0,         32'h00A0_0113, 32'h0050_0093};
        vecs[6] = '{1'b0, 1'b0, 32'h104, 32'h0,         32'h1234_5678, 32'h0050_0093};

        i_req = 0; d_req = 0; d_we = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
        i_req_4 = 0; d_req_4 = 0; d_we_4 = 0; i_addr_4 = 0; d_addr_4 = 0; d_wdata_4 = 0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset mem_en", mem_en, 0);
        chk("reset mem_we", mem_we, 0);
        chk("reset i_ack", i_ack, 0);
        chk("reset d_ack", d_ack, 0);
        chk("reset mem_addr", mem_addr, 0);
        chk("reset mem_wdata", mem_wdata, 0);
        chk("reset i_rdata", i_rdata, 0);
        chk("reset d_rdata", d_rdata, 0);
        chk("reset mem_en_4", mem_en_4, 0);
        RESET_N = 1'b1;

        for (int n = 0; n < 7; n++)
            do_access(vecs[n], n);

        // contention straight after reset: D, I, D, I, D, I every four cycles
        @(negedge CLK);
        RESET_N = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;
        @(posedge CLK); #1;
        i_req = 1'b1; i_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        @(negedge CLK);
        cyc = 0;
        k = 0;
        while (k < 6 && cyc < 40) begin
            if (i_ack || d_ack) begin
                chk($sformatf("contention %0d d_ack", k), d_ack, (k % 2) == 0);
                chk($sformatf("contention %0d i_ack", k), i_ack, (k % 2) == 1);
                chk($sformatf("contention %0d cycle", k), cyc, 3 + 4 * k);
                chk($sformatf("contention %0d other stall", k), (k % 2) == 0 ? i_stall : d_stall, 1);
                k++;
            end
            if (k < 6) begin
                @(negedge CLK);
                cyc++;
            end
        end
        chk("contention grant count", k, 6);
        chk("contention i_rdata", i_rdata, 32'h0050_0093);
        chk("contention d_rdata", d_rdata, 32'hDEAD_BEEF);
        @(posedge CLK); #1;
        i_req = 1'b0; d_req = 1'b0;

        // data request arriving while a fetch is in WAIT
        @(posedge CLK); #1;
        i_req = 1'b1; i_addr = 32'h14;
        @(negedge CLK);
        @(negedge CLK);
        @(posedge CLK); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h104;
        @(negedge CLK);
        chk("stall c2 d_stall", d_stall, 1);
        chk("stall c2 i_stall", i_stall, 1);
        @(negedge CLK);
        chk("stall c3 i_ack", i_ack, 1);
        chk("stall c3 i_stall", i_stall, 0);
        chk("stall c3 d_stall", d_stall, 1);
        chk("stall c3 i_rdata", i_rdata, 32'h00A0_0113);
        @(posedge CLK); #1;
        i_req = 1'b0;
        @(negedge CLK);
        chk("stall c4 d_stall", d_stall, 1);
        chk("stall c4 mem_en", mem_en, 0);
        @(negedge CLK);
        chk("stall c5 mem_en", mem_en, 1);
        chk("stall c5 mem_addr", mem_addr, 32'h104);
        @(negedge CLK);
        chk("stall c6 d_stall", d_stall, 1);
        chk("stall c6 d_ack", d_ack, 0);
        @(negedge CLK);
        chk("stall c7 d_ack", d_ack, 1);
        chk("stall c7 d_stall", d_stall, 0);
        chk("stall c7 d_rdata", d_rdata, 32'h1234_5678);
        @(posedge CLK); #1;
        d_req = 1'b0;

        // reset asserted during WAIT aborts the fetch
        @(posedge CLK); #1;
        i_req = 1'b1; i_addr = 32'h10;
        @(negedge CLK);
        @(negedge CLK);
        @(negedge CLK);
        RESET_N = 1'b0;
        #1;
        chk("abort mem_en", mem_en, 0);
        chk("abort mem_addr", mem_addr, 0);
        chk("abort i_rdata", i_rdata, 0);
        chk("abort d_rdata", d_rdata, 0);
        chk("abort i_ack", i_ack, 0);
        repeat (2) begin
            @(negedge CLK);
            chk("abort held i_ack", i_ack, 0);
            chk("abort held mem_en", mem_en, 0);
        end
        RESET_N = 1'b1;
        @(negedge CLK);
        chk("restart mem_en", mem_en, 1);
        cyc = 1;
        while (!i_ack && cyc < 20) begin
            @(negedge CLK);
            cyc++;
        end
        chk("restart ack cycle", cyc, 3);
        chk("restart i_rdata", i_rdata, 32'h0050_0093);
        @(posedge CLK); #1;
        i_req = 1'b0;

        // LATENCY=4 instance
        @(posedge CLK); #1;
        i_req_4 = 1'b1; i_addr_4 = 32'h10;
        @(negedge CLK);
        chk("lat4 mem_en c0", mem_en_4, 0);
        @(negedge CLK);
        chk("lat4 mem_en c1", mem_en_4, 1);
        chk("lat4 mem_addr", mem_addr_4, 32'h10);
        cyc = 1;
        while (!i_ack_4 && cyc < 30) begin
            @(negedge CLK);
            cyc++;
            if (cyc == 2)
                chk("lat4 mem_en c2", mem_en_4, 0);
        end
        chk("lat4 ack cycle", cyc, 6);
        chk("lat4 i_rdata", i_rdata_4, 32'hCAFE_F00D);
        chk("lat4 d_ack", d_ack_4, 0);
        chk("lat4 d_stall", d_stall_4, 0);
        chk("lat4 i_stall", i_stall_4, 0);
        @(posedge CLK); #1;
        i_req_4 = 1'b0;
        @(negedge CLK);
        chk("lat4 ack pulse width", i_ack_4, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
